// File: rtl/d_latch_if.sv
// Data/reset bundle around a level-sensitive latch. The enable (ck) comes
// in as an interface port so several bundles can share one enable.
interface d_latch_if #(
    parameter int WIDTH = 1
) (
    input logic ck
);
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    // Side that drives data and reset, and observes q.
    modport master (
        input  ck,
        output reset,
        output d,
        input  q
    );

    // Side that implements the storage element.
    modport slave (
        input  ck,
        input  reset,
        input  d,
        output q
    );
endinterface

// File: rtl/d_latch.sv
// Active-high-transparent D latch with a reset that only acts while the
// enable is high. While CK=1 Q follows D (or RESET_VALUE under reset) with
// no edge sampling; while CK=0 Q keeps whatever it held when CK fell.
// Every bit is an independent one-bit latch sharing CK and reset.
// Q has no defined value until the first CK=1 phase.
module d_latch #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CK,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Transparent while CK is high (reset wins over D); holds while CK is low.
    always_latch begin
        if (CK) begin
            if (reset) begin
                Q <= RESET_VALUE;
            end else begin
                Q <= D;
            end
        end
    end

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch: a 1-bit instance and an 8-bit instance (reset value
// 8'hA5) share one enable and one reset. Inputs change only at 5 ns past a
// 10 ns boundary, never on an enable edge; outputs are observed at 1 and
// 6 ns past each boundary so every stable interval is seen once.
module tb_d_latch;

    localparam logic [7:0] RV8 = 8'hA5;

    logic ck;

    d_latch_if #(.WIDTH(1)) if1 (.ck(ck));
    d_latch_if #(.WIDTH(8)) if8 (.ck(ck));

    d_latch #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .CK    (if1.ck),
        .reset (if1.reset),
        .D     (if1.d),
        .Q     (if1.q)
    );

    d_latch #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .CK    (if8.ck),
        .reset (if8.reset),
        .D     (if8.d),
        .Q     (if8.q)
    );

    int vectors    = 0;
    int miscompares = 0;
    bit done       = 0;

    // Clock: period 20 ns, low first, high phases at 10-20, 30-40, ...
    initial begin
        ck = 1'b0;
        forever #10 ck = ~ck;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic drive(input logic rst, input logic d1, input logic [7:0] d8);
        if1.reset = rst;
        if8.reset = rst;
        if1.d     = d1;
        if8.d     = d8;
    endtask

    // Reference model: whenever the enable is high, the stored value becomes
    // the reset value (under reset) or the current data; otherwise it stays.
    // Sampled every 5 ns in the middle of each stable interval.
    logic       model_valid = 1'b0;
    logic       model_q1;
    logic [7:0] model_q8;

    initial begin
        #1;
        while (!done) begin
            if (ck) begin
                model_valid = 1'b1;
                model_q1    = if1.reset ? 1'b0 : if1.d;
                model_q8    = if8.reset ? RV8  : if8.d;
            end
            if (model_valid) begin
                check("model_q1", {7'b0, if1.q}, {7'b0, model_q1});
                check("model_q8", if8.q, model_q8);
            end
            #5;
        end
    end

    // Hand-computed expectations for the directed part of the run.
    initial begin
        at(31);  check("transp_lo",   {7'b0, if1.q}, 8'h00);
        at(36);  check("transp_hi",   {7'b0, if1.q}, 8'h01);
        at(46);  check("held_hi",     {7'b0, if1.q}, 8'h01);
        at(56);  check("mid_follow",  {7'b0, if1.q}, 8'h00);
        at(66);  check("mid_held",    {7'b0, if1.q}, 8'h00);
        at(86);  check("opaque_hold0",{7'b0, if1.q}, 8'h00);
        at(91);  check("open_take1",  {7'b0, if1.q}, 8'h01);
        at(106); check("opaque_hold1",{7'b0, if1.q}, 8'h01);
        at(111); check("open_take0",  {7'b0, if1.q}, 8'h00);
        at(131); check("pulse_hi",    {7'b0, if1.q}, 8'h01);
        at(136); check("pulse_lo",    {7'b0, if1.q}, 8'h00);
        at(146); check("pre_rst_hold",{7'b0, if1.q}, 8'h00);
        at(151); check("pre_rst_take",{7'b0, if1.q}, 8'h01);
        at(166); check("rst_opaque",  {7'b0, if1.q}, 8'h01);
        at(171); check("rst_open1",   {7'b0, if1.q}, 8'h00);
        at(171); check("rst_open8",   if8.q,         8'hA5);
        at(176); check("rst_rel1",    {7'b0, if1.q}, 8'h01);
        at(176); check("rst_rel8",    if8.q,         8'h3C);
        at(186); check("w8_hold",     if8.q,         8'h3C);
        at(191); check("w8_take",     if8.q,         8'hFF);
    end

    // Stimulus: directed sequence, then randomized data and reset.
    initial begin
        drive(1'b0, 1'b0, 8'h3C);
        at(35);  drive(1'b0, 1'b1, 8'h3C);
        at(55);  drive(1'b0, 1'b0, 8'h3C);
        at(85);  drive(1'b0, 1'b1, 8'h3C);
        at(105); drive(1'b0, 1'b0, 8'h3C);
        at(125); drive(1'b0, 1'b1, 8'h3C);
        at(135); drive(1'b0, 1'b0, 8'h3C);
        at(145); drive(1'b0, 1'b1, 8'h3C);
        at(165); drive(1'b1, 1'b1, 8'h3C);
        at(175); drive(1'b0, 1'b1, 8'h3C);
        at(185); drive(1'b0, 1'b1, 8'hFF);
        at(205);
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
            #10;
        end
        #10;
        done = 1'b1;
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
